// File: rtl/heap_memory.sv
`default_nettype none
// ============================================================================
// Module   : heap_memory
// Purpose  : Responder side of the test-harness heap interface. Services
//            array operations (alloc, free, read, write, size, push, pop,
//            resize) from one flat single-port word store. Every array has
//            a fixed capacity of LENGTH words.
// Ports    : clock/reset         - single clock, synchronous active-high reset
//            heapRequest         - one-cycle strobe, captures operation fields
//            heapAction/Array/Index/In - operation code, target, index, data
//            heapOut/heapError   - result word and error code, held until the
//                                  next completion
//            heapDone            - one-cycle pulse when results are valid
//            heapBusy            - high from capture until heapDone
// Revision : 1.0 - initial release
// ============================================================================
module heap_memory #(
  parameter int ARRAYS = 4,
  parameter int LENGTH = 8,
  parameter int WIDTH  = 12,
  localparam int AB    = $clog2(ARRAYS),
  localparam int IB    = $clog2(LENGTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             heapRequest,
  input  logic [7:0]       heapAction,
  input  logic [AB-1:0]    heapArray,
  input  logic [IB-1:0]    heapIndex,
  input  logic [WIDTH-1:0] heapIn,
  output logic [WIDTH-1:0] heapOut,
  output logic [31:0]      heapError,
  output logic             heapDone,
  output logic             heapBusy
);

  localparam int DEPTH = ARRAYS * LENGTH;
  localparam int ADW   = $clog2(DEPTH);

  localparam logic [7:0] c_ACT_ALLOC  = 8'd1;
  localparam logic [7:0] c_ACT_FREE   = 8'd2;
  localparam logic [7:0] c_ACT_READ   = 8'd3;
  localparam logic [7:0] c_ACT_WRITE  = 8'd4;
  localparam logic [7:0] c_ACT_SIZE   = 8'd5;
  localparam logic [7:0] c_ACT_PUSH   = 8'd6;
  localparam logic [7:0] c_ACT_POP    = 8'd7;
  localparam logic [7:0] c_ACT_RESIZE = 8'd8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_EXEC    = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Captured operation fields
  logic [7:0]       r_action;
  logic [AB-1:0]    r_array;
  logic [IB-1:0]    r_index;
  logic [WIDTH-1:0] r_in;

  // Per-array bookkeeping; sizes carry one extra bit so size==LENGTH fits
  logic [ARRAYS-1:0] r_alloc;
  logic [IB:0]       r_size [ARRAYS];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  logic [WIDTH-1:0] r_out;
  logic [31:0]      r_err;
  logic             r_done;

  // Execute-stage decisions
  logic             w_free_found;
  logic [AB-1:0]    w_free_idx;
  logic [IB:0]      w_cur_size;
  logic [IB:0]      w_idx_p1;
  logic [IB-1:0]    w_rd_idx;
  logic [31:0]      w_err;
  logic [WIDTH-1:0] w_out;
  logic             w_we;
  logic [IB-1:0]    w_wr_idx;
  logic             w_size_we;
  logic [IB:0]      w_size_new;
  logic             w_alloc_set;
  logic             w_alloc_clr;
  logic [AB-1:0]    w_tgt;

  function automatic logic [ADW-1:0] f_addr(input logic [AB-1:0] a,
                                            input logic [IB-1:0] i);
    return ADW'(a) * ADW'(LENGTH) + ADW'(i);
  endfunction

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (heapRequest) w_state_next = S_CAPTURE;
      S_CAPTURE: w_state_next = S_EXEC;
      S_EXEC:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Field capture and store read
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_action <= '0;
      r_array  <= '0;
      r_index  <= '0;
      r_in     <= '0;
    end else if (r_state == S_IDLE && heapRequest) begin
      r_action <= heapAction;
      r_array  <= heapArray;
      r_index  <= heapIndex;
      r_in     <= heapIn;
    end
  end

  assign w_cur_size = r_size[r_array];
  // Pop reads the top word; every other action reads at the given index.
  assign w_rd_idx   = (r_action == c_ACT_POP) ? IB'(w_cur_size - (IB+1)'(1)) : r_index;
  assign w_idx_p1   = {1'b0, r_index} + (IB+1)'(1);

  // Single store port: read during CAPTURE, write during EXEC.
  always_ff @(posedge clock) begin
    if (r_state == S_CAPTURE) r_rdata <= r_mem[f_addr(r_array, w_rd_idx)];
    if (w_we)                 r_mem[f_addr(r_array, w_wr_idx)] <= r_in;
  end

  // --------------------------------------------------------------------------
  // Lowest-numbered free array
  // --------------------------------------------------------------------------
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = ARRAYS - 1; i >= 0; i--) begin
      if (!r_alloc[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = AB'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Execute: error checks and commit decisions. All state-changing enables
  // are raised only in success branches, so an error commits nothing.
  // --------------------------------------------------------------------------
  always_comb begin
    w_err       = 32'd0;
    w_out       = r_out;
    w_we        = 1'b0;
    w_wr_idx    = r_index;
    w_size_we   = 1'b0;
    w_size_new  = w_cur_size;
    w_alloc_set = 1'b0;
    w_alloc_clr = 1'b0;
    w_tgt       = r_array;

    if (r_action < c_ACT_ALLOC || r_action > c_ACT_RESIZE) begin
      w_err = 32'd1;
    end else if (r_action != c_ACT_ALLOC && !r_alloc[r_array]) begin
      w_err = 32'd2;
    end else begin
      case (r_action)
        c_ACT_ALLOC: begin
          if (!w_free_found) begin
            w_err = 32'd6;
          end else begin
            w_tgt       = w_free_idx;
            w_alloc_set = 1'b1;
            w_size_we   = 1'b1;
            w_size_new  = '0;
            w_out       = WIDTH'(w_free_idx);
          end
        end
        c_ACT_FREE: begin
          w_alloc_clr = 1'b1;
          w_size_we   = 1'b1;
          w_size_new  = '0;
          w_out       = '0;
        end
        c_ACT_READ: begin
          if ({1'b0, r_index} >= w_cur_size) w_err = 32'd3;
          else                               w_out = r_rdata;
        end
        c_ACT_WRITE: begin
          w_we       = 1'b1;
          w_size_we  = 1'b1;
          w_size_new = (w_idx_p1 > w_cur_size) ? w_idx_p1 : w_cur_size;
          w_out      = r_in;
        end
        c_ACT_SIZE: begin
          w_out = WIDTH'(w_cur_size);
        end
        c_ACT_PUSH: begin
          if (w_cur_size == (IB+1)'(LENGTH)) begin
            w_err = 32'd4;
          end else begin
            w_we       = 1'b1;
            w_wr_idx   = IB'(w_cur_size);
            w_size_we  = 1'b1;
            w_size_new = w_cur_size + (IB+1)'(1);
          end
        end
        c_ACT_POP: begin
          if (w_cur_size == '0) begin
            w_err = 32'd5;
          end else begin
            w_size_we  = 1'b1;
            w_size_new = w_cur_size - (IB+1)'(1);
            w_out      = r_rdata;
          end
        end
        default: begin // resize: compared at full data width
          if (r_in > WIDTH'(LENGTH)) begin
            w_err = 32'd7;
          end else begin
            w_size_we  = 1'b1;
            w_size_new = (IB+1)'(r_in);
          end
        end
      endcase
    end

    if (w_err != 32'd0) w_out = '0;
    if (r_state != S_EXEC) begin
      w_we        = 1'b0;
      w_size_we   = 1'b0;
      w_alloc_set = 1'b0;
      w_alloc_clr = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Commit and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_alloc <= '0;
      for (int i = 0; i < ARRAYS; i++) r_size[i] <= '0;
      r_out   <= '0;
      r_err   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == S_EXEC);
      if (w_alloc_set) r_alloc[w_tgt] <= 1'b1;
      if (w_alloc_clr) r_alloc[w_tgt] <= 1'b0;
      if (w_size_we)   r_size[w_tgt]  <= w_size_new;
      if (r_state == S_EXEC) begin
        r_out <= w_out;
        r_err <= w_err;
      end
    end
  end

  assign heapOut   = r_out;
  assign heapError = r_err;
  assign heapDone  = r_done;
  assign heapBusy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_heap_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_heap_memory
// Purpose  : Randomised scoreboard bench for heap_memory. A behavioural model
//            of the heap predicts each response when a request is issued; a
//            monitor compares every heapDone against the queued prediction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_heap_memory;

  localparam int ARRAYS = 4;
  localparam int LENGTH = 8;
  localparam int WIDTH  = 12;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             heapRequest = 1'b0;
  logic [7:0]       heapAction = '0;
  logic [1:0]       heapArray = '0;
  logic [2:0]       heapIndex = '0;
  logic [WIDTH-1:0] heapIn = '0;
  logic [WIDTH-1:0] heapOut;
  logic [31:0]      heapError;
  logic             heapDone;
  logic             heapBusy;

  heap_memory #(.ARRAYS(ARRAYS), .LENGTH(LENGTH), .WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .heapRequest(heapRequest),
    .heapAction(heapAction), .heapArray(heapArray), .heapIndex(heapIndex),
    .heapIn(heapIn), .heapOut(heapOut), .heapError(heapError),
    .heapDone(heapDone), .heapBusy(heapBusy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [WIDTH-1:0] o;
    logic [31:0]      e;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state
  bit               m_alloc [ARRAYS];
  int               m_size  [ARRAYS];
  logic [WIDTH-1:0] m_mem   [ARRAYS][LENGTH];
  logic [WIDTH-1:0] m_out;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ARRAYS; i++) begin
      m_alloc[i] = 1'b0;
      m_size[i]  = 0;
    end
    m_out = '0;
  endtask

  task automatic model(input logic [7:0] a, input int arr, input int idx,
                       input logic [WIDTH-1:0] din, output exp_t ex);
    int f;
    ex.e = 0;
    ex.o = m_out;
    f    = -1;
    if (a < 1 || a > 8) ex.e = 1;
    else if (a != 1 && !m_alloc[arr]) ex.e = 2;
    else begin
      case (a)
        1: begin
          for (int i = 0; i < ARRAYS; i++) if (!m_alloc[i] && f < 0) f = i;
          if (f < 0) ex.e = 6;
          else begin m_alloc[f] = 1'b1; m_size[f] = 0; ex.o = WIDTH'(f); end
        end
        2: begin m_alloc[arr] = 1'b0; m_size[arr] = 0; ex.o = '0; end
        3: if (idx >= m_size[arr]) ex.e = 3; else ex.o = m_mem[arr][idx];
        4: begin
          m_mem[arr][idx] = din;
          if (idx + 1 > m_size[arr]) m_size[arr] = idx + 1;
          ex.o = din;
        end
        5: ex.o = WIDTH'(m_size[arr]);
        6: if (m_size[arr] == LENGTH) ex.e = 4;
           else begin m_mem[arr][m_size[arr]] = din; m_size[arr]++; end
        7: if (m_size[arr] == 0) ex.e = 5;
           else begin m_size[arr]--; ex.o = m_mem[arr][m_size[arr]]; end
        default: if (int'(din) > LENGTH) ex.e = 7; else m_size[arr] = int'(din);
      endcase
    end
    if (ex.e != 0) ex.o = '0;
    m_out = ex.o;
  endtask

  // Monitor: every completion must match the oldest prediction.
  always @(negedge clock) begin
    if (heapDone) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t ex;
        ex = sb.pop_front();
        check("result", {heapOut, heapError}, {ex.o, ex.e});
      end
    end
  end

  // Issue one operation and verify handshake timing. Optionally pulses a
  // second request while busy, which the DUT must ignore.
  task automatic op(input logic [7:0] a, input int arr, input int idx,
                    input logic [WIDTH-1:0] din, input bit poke);
    exp_t ex;
    int   cnt;
    bit   got;
    @(negedge clock);
    heapAction  = a;
    heapArray   = arr[1:0];
    heapIndex   = idx[2:0];
    heapIn      = din;
    heapRequest = 1'b1;
    model(a, arr, idx, din, ex);
    sb.push_back(ex);
    @(posedge clock); #1;
    heapRequest = 1'b0;
    check("busy_after_req", heapBusy, 1);
    cnt = 0;
    got = 0;
    while (!got && cnt < 10) begin
      if (cnt == 1 && poke) begin
        heapAction  = 8'd1;
        heapRequest = 1'b1;
      end
      @(posedge clock); #1;
      heapRequest = 1'b0;
      cnt++;
      if (heapDone) got = 1;
    end
    check("done_latency", cnt, 2);
    check("busy_in_done", heapBusy, 0);
  endtask

  task automatic reset_midop(input int arr, input int idx, input logic [WIDTH-1:0] din);
    int seen;
    @(negedge clock);
    heapAction  = 8'd4;
    heapArray   = arr[1:0];
    heapIndex   = idx[2:0];
    heapIn      = din;
    heapRequest = 1'b1;
    @(posedge clock); #1;
    heapRequest = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    seen = 0;
    repeat (5) begin
      @(posedge clock); #1;
      if (heapDone) seen++;
    end
    check("no_done_after_reset", seen, 0);
    check("idle_after_reset", {heapBusy, heapOut, heapError}, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    int         r;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("reset_state", {heapOut, heapError, heapDone, heapBusy}, '0);
    @(negedge clock);
    reset = 1'b0;

    // Allocate until exhausted
    for (int i = 0; i < 5; i++) op(8'd1, 0, 0, '0, 0);
    // Fill every word so the model knows all store contents
    for (int arr = 0; arr < ARRAYS; arr++)
      for (int i = 0; i < LENGTH; i++) op(8'd4, arr, i, WIDTH'($urandom), 0);
    for (int arr = 0; arr < ARRAYS; arr++) op(8'd2, arr, 0, '0, 0);

    // Write / size / read / out-of-range read
    op(8'd1, 0, 0, '0, 0);
    op(8'd4, 0, 2, 12'h123, 0);
    op(8'd5, 0, 0, '0, 0);
    op(8'd3, 0, 2, '0, 0);
    op(8'd3, 0, 3, '0, 0);

    // Push to full, pop to empty
    op(8'd1, 0, 0, '0, 0);
    for (int i = 1; i <= 9; i++) op(8'd6, 1, 0, WIDTH'(i), 0);
    op(8'd5, 1, 0, '0, 0);
    for (int i = 0; i < 9; i++) op(8'd7, 1, 0, '0, 0);

    // Error codes and resize
    op(8'd3, 3, 0, '0, 0);
    op(8'hFF, 0, 0, '0, 0);
    op(8'd8, 0, 0, 12'd9, 0);
    op(8'd5, 0, 0, '0, 0);
    op(8'd8, 0, 0, 12'd5, 0);
    op(8'd5, 0, 0, '0, 0);

    // Free/realloc with ignored requests while busy
    op(8'd2, 1, 0, '0, 1);
    op(8'd1, 0, 0, '0, 1);
    op(8'd5, 1, 0, '0, 1);

    // Reset in the middle of a write
    reset_midop(0, 1, 12'hABC);
    op(8'd3, 0, 1, '0, 0);
    op(8'd1, 0, 0, '0, 0);
    op(8'd8, 0, 0, 12'd8, 0);
    op(8'd3, 0, 1, '0, 0);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3)       a = 8'($urandom_range(9, 255));
      else if (r < 5)  a = 8'd0;
      else if (r < 12) a = 8'd1;
      else if (r < 18) a = 8'd2;
      else             a = 8'($urandom_range(3, 8));
      op(a, $urandom_range(0, ARRAYS - 1), $urandom_range(0, LENGTH - 1),
         (a == 8'd8) ? WIDTH'($urandom_range(0, 10)) : WIDTH'($urandom),
         ($urandom_range(0, 3) == 0));
    end

    repeat (4) @(posedge clock);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/heap_memory.md
# heap_memory

Responder side of the test-harness heap interface. Services array operations (allocate, free, read, write, push, pop, size, resize) issued by the program-execution core and returns a result word plus an error code. It is the memory the executing program addresses through its heap action/array/index/in/out signals. All arrays have a fixed capacity and live in one flat word store.

## Interface
Parameters:
- ARRAYS, 4, number of arrays; array number width AB = $clog2(ARRAYS)
- LENGTH, 8, capacity of each array in words; index width IB = $clog2(LENGTH)
- WIDTH, 12, data word width

Ports:
- clock  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- heapRequest  in  1  one-cycle strobe: capture operation fields
- heapAction  in  8  operation code (below)
- heapArray  in  AB  target array number
- heapIndex  in  IB  index within array
- heapIn  in  WIDTH  input data / new size
- heapOut  out  WIDTH  result word, held until next completion
- heapError  out  32  0 = success, else error code, held until next completion
- heapDone  out  1  one-cycle pulse: heapOut/heapError valid
- heapBusy  out  1  high from capture until heapDone

## Operation
- Per-array state: allocated bit, size (0..LENGTH). Data store ARRAYS*LENGTH words, address = array*LENGTH + index; contents not cleared by reset.
- Actions (heapOut shown; unchanged fields keep old value):
  - 1 alloc: lowest-numbered unallocated array marked allocated, size=0; heapOut = its number. None free -> error 6.
  - 2 free: clear allocated, size=0. heapOut=0.
  - 3 read: heapOut = word[index]; index >= size -> error 3.
  - 4 write: word[index]=heapIn; size = max(size, index+1). heapOut = heapIn.
  - 5 size: heapOut = size (zero-extended).
  - 6 push: word[size]=heapIn, size+1; size==LENGTH -> error 4.
  - 7 pop: size-1, heapOut = word[size-1]; size==0 -> error 5.
  - 8 resize: size = heapIn; heapIn > LENGTH -> error 7.
  - any other code -> error 1.
- Actions 2-8 on an unallocated array -> error 2. Check priority: 1, then 2, then operation-specific.
- On any error no state (sizes, alloc bits, data) changes; heapOut = 0.
- States: IDLE -> (heapRequest) CAPTURE -> EXEC -> IDLE with heapDone asserted on EXEC->IDLE transition. CAPTURE registers fields and issues store read (for read/pop); EXEC checks errors, commits writes, drives results.
- heapRequest while heapBusy is ignored (no capture, no error).

## Timing
- Reset values: heapOut=0, heapError=0, heapDone=0, heapBusy=0, all alloc bits 0, all sizes 0, state IDLE.
- heapRequest sampled high at edge N -> heapBusy=1 after N; heapDone=1 for exactly the cycle after edge N+2; heapBusy=0 in that same cycle. Back-to-back throughput: one operation per 3 cycles (next request may be at edge N+3 earliest, i.e. during the heapDone cycle).
- Store: single-port synchronous; read data available one cycle after address.
- Write then read of same location in consecutive operations returns new data (writes commit at EXEC edge, before next CAPTURE).
- Reset asserted mid-operation: operation aborted, no heapDone, no state committed; reset wins over heapRequest in same cycle.
- Sizes are IB+1 bits wide so size==LENGTH is representable; heapIn compared at full WIDTH for resize.

## Test plan
- Reset, then alloc x5 (ARRAYS=4) -> heapOut 0,1,2,3 with error 0, fifth returns error 6, heapOut 0.
- Alloc a0; write idx 2 = 12'h123; size -> 3; read idx 2 -> 12'h123; read idx 3 -> error 3.
- Push 8 values 1..8 into fresh array, push 9th -> error 4, size stays 8; pop x8 -> 8..1, pop 9th -> error 5.
- Read on unallocated array 3 -> error 2; action 8'hFF -> error 1; resize heapIn=9 -> error 7, size unchanged; resize 5 -> size reads 5.
- Free a1, alloc -> returns 1 with size 0; heapDone exactly 3 cycles after each request, heapRequest during heapBusy produces no extra heapDone.
- Assert reset the cycle after a write request -> no heapDone, following read of that index returns pre-reset data and array reported unallocated (error 2).
